// File: rtl/rf_seq_master_if.sv
// Register-file write/read ports plus the dump beat stream, seen from the sequencer (master).
// Read data returns combinationally from the read addresses; dump beats use dv_o/dready_i.
interface rf_seq_master_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          regwrite_o;
    logic [AW-1:0] wa_o;
    logic [DW-1:0] wd_o;
    logic [AW-1:0] ra0_o;
    logic [DW-1:0] rd0_i;
    logic [AW-1:0] ra1_o;
    logic [DW-1:0] rd1_i;
    logic          dv_o;
    logic          dready_i;
    logic [AW-1:0] didx_o;
    logic [DW-1:0] dd_o;

    modport master (
        output regwrite_o, wa_o, wd_o, ra0_o, ra1_o, dv_o, didx_o, dd_o,
        input  rd0_i, rd1_i, dready_i
    );

    modport slave (
        input  regwrite_o, wa_o, wd_o, ra0_o, ra1_o, dv_o, didx_o, dd_o,
        output rd0_i, rd1_i, dready_i
    );
endinterface

// File: rtl/rf_seq_master.sv
// Regfile sequencer: fill+read-back verify and/or dump of every register over valid/ready.
// Fill takes NREG+1 cycles; first dump beat 1 cycle after DUMP entry; dump stalls hold beat.
module rf_seq_master #(
    parameter int DW   = 32,
    parameter int AW   = 5,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [1:0]      mode_i,
    input  logic [DW-1:0]   pat_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o,
    output logic [AW-1:0]   err_idx_o,
    rf_seq_master_if.master rf
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_FVER,
        S_DUMP,
        S_DONE
    } state_t;

    localparam int            CW       = AW + 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);
    localparam logic [CW-1:0] NREG_CNT = CW'(NREG);

    state_t        state_q, state_d;
    logic [DW-1:0] pat_q;
    logic          dump_after_q;
    logic [AW-1:0] wa_q;
    logic [DW-1:0] wd_q;
    logic [AW-1:0] ra1_q;
    logic [CW-1:0] dump_idx_q;
    logic          dv_q;
    logic [AW-1:0] didx_q;
    logic [DW-1:0] dd_q;
    logic          err_q;
    logic [AW-1:0] err_idx_q;

    logic start_acc;
    logic fill_mode;
    logic last_wr;
    logic last_beat;
    logic chk_en;
    logic mismatch;
    logic dump_load;

    assign start_acc = (state_q == S_IDLE) && start_i;
    assign fill_mode = (mode_i == 2'b01) || (mode_i == 2'b10);
    assign last_wr   = (wa_q == LAST_IDX);
    assign last_beat = dv_q && rf.dready_i && (didx_q == LAST_IDX);
    // ra1 trails the write address by one, so reg k-1 is checked while reg k is written
    assign chk_en    = ((state_q == S_FILL) && (wa_q != '0)) || (state_q == S_FVER);
    assign mismatch  = chk_en && (rf.rd1_i != (pat_q + DW'(ra1_q)));
    assign dump_load = (state_q == S_DUMP) && (!dv_q || rf.dready_i) && (dump_idx_q < NREG_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        busy_o        = 1'b0;
        done_o        = 1'b0;
        rf.regwrite_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = fill_mode ? S_FILL : S_DUMP;
                end
            end
            S_FILL: begin
                busy_o        = 1'b1;
                rf.regwrite_o = 1'b1;
                if (last_wr) begin
                    state_d = S_FVER;
                end
            end
            S_FVER: begin
                busy_o  = 1'b1;
                state_d = dump_after_q ? S_DUMP : S_DONE;
            end
            S_DUMP: begin
                busy_o = 1'b1;
                if (last_beat) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                busy_o  = 1'b1;
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q        <= '0;
            dump_after_q <= 1'b0;
            wa_q         <= '0;
            wd_q         <= '0;
            ra1_q        <= '0;
            dump_idx_q   <= '0;
            dv_q         <= 1'b0;
            didx_q       <= '0;
            dd_q         <= '0;
            err_q        <= 1'b0;
            err_idx_q    <= '0;
        end else begin
            if (start_acc) begin
                pat_q        <= pat_i;
                dump_after_q <= (mode_i == 2'b10);
                err_q        <= 1'b0;
                err_idx_q    <= '0;
                if (fill_mode) begin
                    wa_q  <= '0;
                    wd_q  <= pat_i;
                    ra1_q <= '0;
                end
            end

            // Address/data stop on the last register so they hold it after the fill
            if (state_q == S_FILL) begin
                ra1_q <= wa_q;
                if (!last_wr) begin
                    wa_q <= wa_q + AW'(1);
                    wd_q <= wd_q + DW'(1);
                end
            end

            if (mismatch) begin
                err_q <= 1'b1;
                if (!err_q) begin
                    err_idx_q <= ra1_q;
                end
            end

            if (state_q == S_DUMP) begin
                if (dump_load) begin
                    dd_q       <= rf.rd0_i;
                    didx_q     <= dump_idx_q[AW-1:0];
                    dv_q       <= 1'b1;
                    dump_idx_q <= dump_idx_q + CW'(1);
                end else if (dv_q && rf.dready_i) begin
                    dv_q <= 1'b0;
                end
            end else begin
                dump_idx_q <= '0;
            end
        end
    end

    assign rf.wa_o   = wa_q;
    assign rf.wd_o   = wd_q;
    assign rf.ra1_o  = ra1_q;
    assign rf.ra0_o  = dump_idx_q[AW-1:0];
    assign rf.dv_o   = dv_q;
    assign rf.didx_o = didx_q;
    assign rf.dd_o   = dd_q;
    assign err_o     = err_q;
    assign err_idx_o = err_idx_q;
endmodule

// File: tb/tb_rf_seq_master.sv
// Bench for rf_seq_master: regfile model with optional stuck bit, random stimulus,
// expectations computed from the register-level rules (pat+i per register, first bad index).
module tb_rf_seq_master;
    localparam int DW        = 32;
    localparam int AW        = 5;
    localparam int NREG      = 32;
    localparam int FAULT_REG = 7;
    localparam int FAULT_BIT = 3;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          start    = 1'b0;
    logic [1:0]    mode     = 2'b00;
    logic [DW-1:0] pat      = '0;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW-1:0] err_idx;
    logic          fault    = 1'b0;
    logic          rand_rdy = 1'b0;
    logic          rdy      = 1'b1;

    logic [DW-1:0] mem      [NREG];
    logic [DW-1:0] exp_dump [NREG];
    logic [DW-1:0] exp_pat  = '0;

    // monitor-owned counters
    int n_wr = 0, n_wr_bad = 0, n_busy = 0, n_done = 0;
    int n_beat = 0, n_beat_bad = 0, n_stall_bad = 0;
    // per-operation bases and expectations
    int wr_base = 0, beat_base = 0, busy_base = 0, done_base = 0;
    int wrbad_base = 0, beatbad_base = 0, stallbad_base = 0;
    int exp_wr, exp_beats, exp_busy;
    logic exp_fill, exp_has_dump, exp_err;
    logic [AW-1:0] exp_err_idx;

    int total = 0;
    int bad   = 0;

    rf_seq_master_if #(.DW(DW), .AW(AW)) bus ();

    rf_seq_master #(.DW(DW), .AW(AW), .NREG(NREG)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start),
        .mode_i    (mode),
        .pat_i     (pat),
        .busy_o    (busy),
        .done_o    (done),
        .err_o     (err),
        .err_idx_o (err_idx),
        .rf        (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] stored(input logic [DW-1:0] v, input int i, input logic f);
        if (f && i == FAULT_REG) return v & ~(DW'(1) << FAULT_BIT);
        return v;
    endfunction

    assign bus.rd0_i    = mem[bus.ra0_o];
    assign bus.rd1_i    = mem[bus.ra1_o];
    assign bus.dready_i = rdy;

    always @(posedge clk) begin
        if (bus.regwrite_o) mem[bus.wa_o] <= stored(bus.wd_o, int'(bus.wa_o), fault);
    end

    always @(posedge clk) begin
        #1;
        rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    logic          stall_prev = 1'b0;
    logic [AW-1:0] prev_idx   = '0;
    logic [DW-1:0] prev_dd    = '0;
    int            bi;

    always @(negedge clk) begin
        if (bus.regwrite_o) begin
            if (bus.wa_o != AW'(n_wr - wr_base) || bus.wd_o != exp_pat + DW'(n_wr - wr_base))
                n_wr_bad++;
            n_wr++;
        end
        if (busy) n_busy++;
        if (done) n_done++;
        if (stall_prev && (!bus.dv_o || bus.didx_o != prev_idx || bus.dd_o != prev_dd))
            n_stall_bad++;
        if (bus.dv_o && rdy) begin
            bi = n_beat - beat_base;
            if (bi >= NREG || bi < 0) n_beat_bad++;
            else if (bus.didx_o != AW'(bi) || bus.dd_o != exp_dump[bi]) n_beat_bad++;
            n_beat++;
        end
        stall_prev = bus.dv_o && !rdy;
        prev_idx   = bus.didx_o;
        prev_dd    = bus.dd_o;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, expv);
        end
    endtask

    task automatic start_op(input logic [1:0] m, input logic [DW-1:0] p);
        logic [DW-1:0] want;
        exp_fill     = (m == 2'b01) || (m == 2'b10);
        exp_has_dump = (m != 2'b01);
        exp_err      = 1'b0;
        exp_err_idx  = '0;
        for (int i = 0; i < NREG; i++) begin
            want        = p + DW'(i);
            exp_dump[i] = exp_fill ? stored(want, i, fault) : mem[i];
            if (exp_fill && exp_dump[i] != want && !exp_err) begin
                exp_err     = 1'b1;
                exp_err_idx = AW'(i);
            end
        end
        exp_wr    = exp_fill ? NREG : 0;
        exp_beats = exp_has_dump ? NREG : 0;
        exp_busy  = (exp_fill ? NREG + 1 : 0) + (exp_has_dump ? NREG + 1 : 0) + 1;
        exp_pat       = p;
        wr_base       = n_wr;
        beat_base     = n_beat;
        busy_base     = n_busy;
        done_base     = n_done;
        wrbad_base    = n_wr_bad;
        beatbad_base  = n_beat_bad;
        stallbad_base = n_stall_bad;
        @(posedge clk); #1;
        start = 1'b1;
        mode  = m;
        pat   = p;
        @(posedge clk); #1;
        start = 1'b0;
        mode  = 2'($urandom);
        pat   = $urandom;
    endtask

    task automatic finish_op();
        logic seen;
        int   nbad;
        seen = 1'b0;
        for (int c = 0; c < 2000 && !seen; c++) begin
            @(negedge clk); #1;
            if (n_done != done_base) seen = 1'b1;
        end
        chk("done_seen", seen, 1);
        @(negedge clk); #1;
        chk("busy_after_done", busy, 0);
        chk("done_pulses", n_done - done_base, 1);
        if (!(rand_rdy && exp_has_dump)) chk("busy_cycles", n_busy - busy_base, exp_busy);
        chk("writes", n_wr - wr_base, exp_wr);
        chk("write_addr_data", n_wr_bad - wrbad_base, 0);
        chk("beats", n_beat - beat_base, exp_beats);
        chk("beat_idx_data", n_beat_bad - beatbad_base, 0);
        chk("stall_stable", n_stall_bad - stallbad_base, 0);
        chk("err", err, exp_err);
        chk("err_idx", err_idx, exp_err_idx);
        if (exp_fill) begin
            nbad = 0;
            for (int i = 0; i < NREG; i++) if (mem[i] !== exp_dump[i]) nbad++;
            chk("mem_contents", nbad, 0);
        end
    endtask

    initial begin
        logic [DW-1:0] p;
        logic          found;
        int            d0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", {busy, done, err, bus.regwrite_o, bus.dv_o}, 0);
        chk("rst_addr", {err_idx, bus.wa_o, bus.ra0_o, bus.ra1_o, bus.didx_o}, 0);
        chk("rst_data", {bus.wd_o, bus.dd_o}, 0);
        rst_n = 1'b1;

        start_op(2'b01, 32'h1000_0000);
        finish_op();

        start_op(2'b01, 32'hFFFF_FFF0);
        finish_op();
        chk("wrap_reg16", mem[16], 0);

        fault = 1'b1;
        start_op(2'b01, 32'h0000_0008);
        finish_op();
        repeat (5) @(negedge clk);
        #1;
        chk("err_hold", err, 1);
        chk("err_idx_hold", err_idx, FAULT_REG);
        fault = 1'b0;
        start_op(2'b01, $urandom);
        chk("err_clr", err, 0);
        chk("err_idx_clr", err_idx, 0);
        finish_op();

        rand_rdy = 1'b0;
        start_op(2'b00, $urandom);
        finish_op();

        rand_rdy = 1'b1;
        start_op(2'b10, $urandom);
        finish_op();

        start_op(2'b11, $urandom);
        finish_op();

        // start pulses while busy must not disturb the running fill
        rand_rdy = 1'b0;
        p = $urandom;
        start_op(2'b01, p);
        repeat (8) @(posedge clk);
        #1; start = 1'b1; mode = 2'b10; pat = ~p;
        @(posedge clk); #1; start = 1'b0;
        repeat (10) @(posedge clk);
        #1; start = 1'b1; mode = 2'b00; pat = p ^ 32'h5A5A_5A5A;
        @(posedge clk); #1; start = 1'b0;
        finish_op();

        // reset in the middle of the fill, at write index 10
        start_op(2'b01, $urandom);
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk); #1;
            if (bus.regwrite_o && bus.wa_o == AW'(10)) found = 1'b1;
        end
        chk("rst_mid_found_k10", found, 1);
        d0 = n_done;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ctrl", {busy, done, err, bus.regwrite_o, bus.dv_o}, 0);
        chk("rst_mid_addr", {err_idx, bus.wa_o, bus.ra0_o, bus.ra1_o, bus.didx_o}, 0);
        chk("rst_mid_data", {bus.wd_o, bus.dd_o}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_mid_no_done", n_done - d0, 0);
        start_op(2'b01, $urandom);
        finish_op();

        for (int it = 0; it < 6; it++) begin
            rand_rdy = 1'($urandom_range(0, 1));
            fault    = ($urandom_range(0, 3) == 0);
            start_op(2'($urandom_range(0, 3)), $urandom);
            finish_op();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
